// File: rtl/vector_component_sequencer_if.sv
// Handshake bundle for the vector sequencer: vector+mask in, tagged scalar beats out.
interface vector_component_sequencer_if #(
  parameter int FP_W = 32
);
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic [3:0][FP_W-1:0] i_vector;
  logic [3:0]           i_mask;
  logic                 o_out_valid;
  logic                 i_out_ready;
  logic [FP_W-1:0]      o_component;
  logic [1:0]           o_index;
  logic                 o_last;
  logic                 o_drop;

  modport slave (
    input  i_in_valid, i_vector, i_mask, i_out_ready,
    output o_in_ready, o_out_valid, o_component, o_index, o_last, o_drop
  );

  modport master (
    output i_in_valid, i_vector, i_mask, i_out_ready,
    input  o_in_ready, o_out_valid, o_component, o_index, o_last, o_drop
  );
endinterface

// File: rtl/vector_component_sequencer.sv
// Serialises the enabled components of one 4-lane fixed-point vector onto a
// single scalar beat stream, tagged with lane index and a last flag.
module vector_component_sequencer #(
  parameter bit REVERSE_ORDER = 1'b0,
  parameter int FP_W          = 32
) (
  input logic                         i_clk,
  input logic                         i_reset,
  vector_component_sequencer_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_n;
  logic [3:0][FP_W-1:0] vec_q, vec_n;
  logic [3:0]           rem_q, rem_n;
  logic                 drop_q, drop_n;

  logic [1:0]           cur;
  logic                 one_left;
  logic                 out_valid, last, in_ready, accept, beat;
  logic [FP_W-1:0]      component;
  logic [1:0]           index;

  // Priority pick of the next lane; the loop direction decides which set bit wins.
  always_comb begin
    cur = '0;
    if (REVERSE_ORDER) begin
      for (int i = 0; i < 4; i++) if (rem_q[i]) cur = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--) if (rem_q[i]) cur = 2'(i);
    end
  end

  assign one_left = (rem_q != 4'b0) && ((rem_q & (rem_q - 4'b1)) == 4'b0);

  // Output process: beat fields are a pure function of the registered state.
  always_comb begin
    out_valid = 1'b0;
    component = '0;
    index     = '0;
    last      = 1'b0;
    if (state == STREAM) begin
      out_valid = 1'b1;
      component = vec_q[cur];
      index     = cur;
      last      = one_left;
    end
  end

  assign in_ready = !i_reset &&
                    ((state == IDLE) || ((state == STREAM) && last && bus.i_out_ready));
  assign accept   = bus.i_in_valid && in_ready;
  assign beat     = out_valid && bus.i_out_ready;

  // Next-state process: a load on the last-beat cycle overrides the beat's IDLE return.
  always_comb begin
    state_n = state;
    vec_n   = vec_q;
    rem_n   = rem_q;
    drop_n  = 1'b0;
    if (beat) begin
      rem_n = rem_q & ~(4'b0001 << cur);
      if (last) state_n = IDLE;
    end
    if (accept) begin
      vec_n   = bus.i_vector;
      rem_n   = bus.i_mask;
      state_n = (bus.i_mask != 4'b0) ? STREAM : IDLE;
      drop_n  = (bus.i_mask == 4'b0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      vec_q  <= '0;
      rem_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_n;
      vec_q  <= vec_n;
      rem_q  <= rem_n;
      drop_q <= drop_n;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_out_valid = out_valid;
  assign bus.o_component = component;
  assign bus.o_index     = index;
  assign bus.o_last      = last;
  assign bus.o_drop      = drop_q;
endmodule

// File: tb/tb_vector_component_sequencer.sv
// Scoreboard bench: ascending and descending sequencers share one stimulus stream.
module tb_vector_component_sequencer;
  localparam int FP_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 in_valid;
  logic [3:0][FP_W-1:0] vec;
  logic [3:0]           mask;
  logic                 rdy;

  vector_component_sequencer_if #(.FP_W(FP_W)) bus0 ();
  vector_component_sequencer_if #(.FP_W(FP_W)) bus1 ();

  assign bus0.i_in_valid  = in_valid;
  assign bus0.i_vector    = vec;
  assign bus0.i_mask      = mask;
  assign bus0.i_out_ready = rdy;
  assign bus1.i_in_valid  = in_valid;
  assign bus1.i_vector    = vec;
  assign bus1.i_mask      = mask;
  assign bus1.i_out_ready = rdy;

  vector_component_sequencer #(.REVERSE_ORDER(1'b0), .FP_W(FP_W)) dut_asc (
    .i_clk(clk), .i_reset(rst), .bus(bus0));
  vector_component_sequencer #(.REVERSE_ORDER(1'b1), .FP_W(FP_W)) dut_desc (
    .i_clk(clk), .i_reset(rst), .bus(bus1));

  logic [1:0]           ov, ir, ol, od;
  logic [1:0][1:0]      oi;
  logic [1:0][FP_W-1:0] oc;
  assign ov = {bus1.o_out_valid, bus0.o_out_valid};
  assign ir = {bus1.o_in_ready,  bus0.o_in_ready};
  assign ol = {bus1.o_last,      bus0.o_last};
  assign od = {bus1.o_drop,      bus0.o_drop};
  assign oi = {bus1.o_index,     bus0.o_index};
  assign oc = {bus1.o_component, bus0.o_component};

  typedef struct {
    logic [FP_W-1:0] val;
    logic [1:0]      idx;
    logic            last;
  } beat_t;

  beat_t exp_q[2][$];
  int    errors = 0;
  int    checks = 0;
  logic  exp_drop = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list the enabled lanes in emission order; the final one carries last.
  task automatic model_accept(input logic [3:0] m, input logic [3:0][FP_W-1:0] v);
    beat_t b;
    int    n, k, i;
    n = $countones(m);
    for (int d = 0; d < 2; d++) begin
      k = 0;
      for (int j = 0; j < 4; j++) begin
        i = (d == 1) ? 3 - j : j;
        if (m[i]) begin
          k++;
          b.val  = v[i];
          b.idx  = 2'(i);
          b.last = (k == n);
          exp_q[d].push_back(b);
        end
      end
    end
  endtask

  // Input side: ready/valid/drop expectations and recording of accepted vectors.
  initial begin : in_side
    logic acc;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("ready_in_reset%0d", d), ir[d], 1'b0);
          exp_q[d].delete();
        end
        exp_drop = 1'b0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("drop%0d", d), od[d], exp_drop);
          chk($sformatf("out_valid%0d", d), ov[d], exp_q[d].size() > 0);
          exp_rdy = (exp_q[d].size() == 0) || (exp_q[d].size() == 1 && rdy);
          chk($sformatf("in_ready%0d", d), ir[d], exp_rdy);
        end
        acc      = in_valid && ir[0];
        exp_drop = acc && (mask == 4'b0);
        if (acc) model_accept(mask, vec);
      end
    end
  end

  // Output monitor: pops and compares every taken beat, and checks stall stability.
  initial begin : out_side
    logic [1:0]           stall;
    logic [1:0][FP_W-1:0] s_val;
    logic [1:0][1:0]      s_idx;
    logic [1:0]           s_last;
    beat_t                b;
    stall = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stall = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (ov[d]) begin
            if (stall[d]) begin
              chk($sformatf("hold_val%0d", d), oc[d], s_val[d]);
              chk($sformatf("hold_idx%0d", d), oi[d], s_idx[d]);
              chk($sformatf("hold_last%0d", d), ol[d], s_last[d]);
            end
            if (rdy) begin
              stall[d] = 1'b0;
              if (exp_q[d].size() == 0) begin
                chk($sformatf("unexpected_beat%0d", d), 1'b1, 1'b0);
              end else begin
                b = exp_q[d].pop_front();
                chk($sformatf("beat_val%0d", d), oc[d], b.val);
                chk($sformatf("beat_idx%0d", d), oi[d], b.idx);
                chk($sformatf("beat_last%0d", d), ol[d], b.last);
              end
            end else begin
              stall[d]  = 1'b1;
              s_val[d]  = oc[d];
              s_idx[d]  = oi[d];
              s_last[d] = ol[d];
            end
          end else begin
            if (stall[d]) chk($sformatf("valid_dropped%0d", d), 1'b0, 1'b1);
            stall[d] = 1'b0;
            chk($sformatf("idle_outputs%0d", d), {oc[d], oi[d], ol[d]}, '0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [3:0][FP_W-1:0] v);
    logic acc;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    mask     = m;
    vec      = v;
    acc      = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = bus0.o_in_ready;
      step();
      n++;
      if (!acc && n > 50) begin
        chk("send_timeout", 1'b1, 1'b0);
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  logic [3:0][FP_W-1:0] v1234;
  int                   guard;

  initial begin
    v1234    = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    rst      = 1'b1;
    in_valid = 1'b0;
    mask     = '0;
    vec      = '0;
    rdy      = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    send(4'b1111, v1234);
    idle(6);
    send(4'b1010, v1234);
    idle(4);

    // Backpressure on the second beat
    send(4'b0111, v1234);
    in_valid = 1'b0;
    step();
    rdy = 1'b0;
    repeat (3) step();
    rdy = 1'b1;
    idle(4);

    send(4'b0011, v1234);
    send(4'b1000, v1234);
    idle(4);

    send(4'b0000, v1234);
    idle(3);
    send(4'b0001, v1234);
    send(4'b0000, v1234);
    idle(3);

    // Reset after the first of four beats
    send(4'b1111, v1234);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(4'b0001, v1234);
    idle(3);

    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 79) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      mask     = 4'($urandom);
      for (int i = 0; i < 4; i++) vec[i] = $urandom;
      rdy      = ($urandom_range(0, 3) != 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    rdy      = 1'b1;
    guard    = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 20) begin
      step();
      guard++;
    end
    step();
    chk("drain_asc", exp_q[0].size(), 0);
    chk("drain_desc", exp_q[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
